// File: rtl/div_metrics_pkg.sv
// Shared types, sizes and the saturating-add helper for the divider error monitor.
package div_metrics_pkg;

  typedef enum logic [1:0] {IDLE, DIV, ACC} state_t;

  localparam int DIV_STEPS = 8;
  localparam int X_W       = 16;
  localparam int Y_W       = 8;

  // Adds b to a and clamps the result at the all-ones value of a w-bit field.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) return lim[63:0];
    return sum[63:0];
  endfunction

endpackage

// File: rtl/exact_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract y if it fits.
module exact_div_step
  import div_metrics_pkg::*;
(
  input  logic [Y_W-1:0] p,
  input  logic           x_bit,
  input  logic [Y_W-1:0] y,
  output logic [Y_W-1:0] p_next,
  output logic           q_bit
);

  logic [Y_W:0] t;
  logic [Y_W:0] diff;

  assign t      = {p, x_bit};
  assign diff   = t - {1'b0, y};
  assign q_bit  = (t >= {1'b0, y});
  // p < y on entry keeps t < 2y, so the difference always fits in Y_W bits.
  assign p_next = q_bit ? diff[Y_W-1:0] : t[Y_W-1:0];

endmodule

// File: rtl/div_err_monitor.sv
// Recomputes each sample's exact quotient/remainder and accumulates saturating
// error statistics against the approximate divider's outputs.
module div_err_monitor
  import div_metrics_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SUM_W = 40
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [X_W-1:0]   x,
  input  logic [Y_W-1:0]   y,
  input  logic [Y_W-1:0]   q_app,
  input  logic [Y_W-1:0]   r_app,
  input  logic             clr,
  output logic             upd,
  output logic [CNT_W-1:0] n_samples,
  output logic [CNT_W-1:0] n_err,
  output logic [CNT_W-1:0] n_oor,
  output logic [SUM_W-1:0] sum_ed_q,
  output logic [Y_W-1:0]   max_ed_q
);

  localparam int STEP_W = $clog2(DIV_STEPS);

  state_t state, state_next;

  logic [Y_W-1:0]    x_lo_r;
  logic [Y_W-1:0]    y_r;
  logic [Y_W-1:0]    q_app_r;
  logic [Y_W-1:0]    r_app_r;
  logic [Y_W-1:0]    p_r;
  logic [Y_W-1:0]    q_r;
  logic [STEP_W-1:0] step;
  logic              oor_r;

  logic              xfer;
  logic              in_range;
  logic [Y_W-1:0]    p_next;
  logic              q_bit;
  logic [Y_W-1:0]    ed;
  logic              mismatch;

  assign in_ready = (state == IDLE);
  assign xfer     = in_valid & in_ready & ~clr;
  assign in_range = (y != '0) && (x[X_W-1:Y_W] < y);
  assign ed       = (q_r >= q_app_r) ? (q_r - q_app_r) : (q_app_r - q_r);
  assign mismatch = (q_r != q_app_r) || (p_r != r_app_r);

  exact_div_step u_step (
    .p      (p_r),
    .x_bit  (x_lo_r[step]),
    .y      (y_r),
    .p_next (p_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (xfer) state_next = in_range ? DIV : ACC;
      DIV:     if (step == '0) state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clr) state_next = IDLE;
  end

  // Partial remainder starts as the dividend's high byte; quotient bits fill MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_lo_r  <= '0;
      y_r     <= '0;
      q_app_r <= '0;
      r_app_r <= '0;
      p_r     <= '0;
      q_r     <= '0;
      step    <= '0;
      oor_r   <= 1'b0;
    end else if (xfer) begin
      x_lo_r  <= x[Y_W-1:0];
      y_r     <= y;
      q_app_r <= q_app;
      r_app_r <= r_app;
      p_r     <= x[X_W-1:Y_W];
      q_r     <= '0;
      step    <= STEP_W'(DIV_STEPS - 1);
      oor_r   <= ~in_range;
    end else if (state == DIV) begin
      p_r       <= p_next;
      q_r[step] <= q_bit;
      step      <= step - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd       <= 1'b0;
      n_samples <= '0;
      n_err     <= '0;
      n_oor     <= '0;
      sum_ed_q  <= '0;
      max_ed_q  <= '0;
    end else begin
      upd <= 1'b0;
      if (clr) begin
        n_samples <= '0;
        n_err     <= '0;
        n_oor     <= '0;
        sum_ed_q  <= '0;
        max_ed_q  <= '0;
      end else if (state == ACC) begin
        upd <= 1'b1;
        if (oor_r) begin
          n_oor <= CNT_W'(sat_add(64'(n_oor), 64'd1, CNT_W));
        end else begin
          n_samples <= CNT_W'(sat_add(64'(n_samples), 64'd1, CNT_W));
          sum_ed_q  <= SUM_W'(sat_add(64'(sum_ed_q), 64'(ed), SUM_W));
          if (ed > max_ed_q) max_ed_q <= ed;
          if (mismatch) n_err <= CNT_W'(sat_add(64'(n_err), 64'd1, CNT_W));
        end
      end
    end
  end

endmodule

// File: tb/tb_div_err_monitor.sv
// Bench for div_err_monitor: fixed vectors, handshake/clear/reset sequences and
// randomized samples checked against an arithmetic reference model.
module tb_div_err_monitor;

  localparam int CNT_W  = 32;
  localparam int CNT_W4 = 4;
  localparam int SUM_W  = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic clr = 1'b0;
  logic [15:0] x = '0;
  logic [7:0]  y = '0;
  logic [7:0]  q_app = '0;
  logic [7:0]  r_app = '0;

  logic             in_ready, upd;
  logic [CNT_W-1:0] n_samples, n_err, n_oor;
  logic [SUM_W-1:0] sum_ed_q;
  logic [7:0]       max_ed_q;

  logic              in_ready4, upd4;
  logic [CNT_W4-1:0] n_samples4, n_err4, n_oor4;
  logic [SUM_W-1:0]  sum_ed_q4;
  logic [7:0]        max_ed_q4;

  int checks = 0;
  int errors = 0;

  longint unsigned m_ns, m_ne, m_noor, m_sum, m_max;

  typedef struct {
    logic [15:0]     vx;
    logic [7:0]      vy;
    logic [7:0]      vq;
    logic [7:0]      vr;
    int              lat;
    longint unsigned ns;
    longint unsigned ne;
    longint unsigned noor;
    longint unsigned sum;
    longint unsigned mx;
  } vec_t;

  vec_t vecs[7];

  div_err_monitor #(.CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .q_app(q_app), .r_app(r_app), .clr(clr), .upd(upd),
    .n_samples(n_samples), .n_err(n_err), .n_oor(n_oor),
    .sum_ed_q(sum_ed_q), .max_ed_q(max_ed_q)
  );

  div_err_monitor #(.CNT_W(CNT_W4), .SUM_W(SUM_W)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .x(x), .y(y), .q_app(q_app), .r_app(r_app), .clr(clr), .upd(upd4),
    .n_samples(n_samples4), .n_err(n_err4), .n_oor(n_oor4),
    .sum_ed_q(sum_ed_q4), .max_ed_q(max_ed_q4)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic longint unsigned sat(input longint unsigned v, input int w);
    longint unsigned lim;
    if (w >= 64) return v;
    lim = (64'd1 << w) - 64'd1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic checkOutput(input string name, input longint unsigned act,
                             input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic modelClear();
    m_ns = 0; m_ne = 0; m_noor = 0; m_sum = 0; m_max = 0;
  endtask

  function automatic bit isOor(input logic [15:0] vx, input logic [7:0] vy);
    return (vy == 0) || (int'(vx[15:8]) >= int'(vy));
  endfunction

  // Reference: plain integer division and absolute difference.
  task automatic modelAccept(input logic [15:0] vx, input logic [7:0] vy,
                             input logic [7:0] vq, input logic [7:0] vr);
    int qe, re, ed;
    if (isOor(vx, vy)) begin
      m_noor++;
    end else begin
      qe = int'(vx) / int'(vy);
      re = int'(vx) % int'(vy);
      ed = (qe > int'(vq)) ? qe - int'(vq) : int'(vq) - qe;
      m_ns++;
      m_sum += longint'(ed);
      if (longint'(ed) > m_max) m_max = longint'(ed);
      if (qe != int'(vq) || re != int'(vr)) m_ne++;
    end
  endtask

  task automatic checkStats(input string tag);
    checkOutput({tag, "_n_samples"}, n_samples, sat(m_ns, CNT_W));
    checkOutput({tag, "_n_err"}, n_err, sat(m_ne, CNT_W));
    checkOutput({tag, "_n_oor"}, n_oor, sat(m_noor, CNT_W));
    checkOutput({tag, "_sum_ed_q"}, sum_ed_q, sat(m_sum, SUM_W));
    checkOutput({tag, "_max_ed_q"}, max_ed_q, m_max);
    checkOutput({tag, "_n_samples4"}, n_samples4, sat(m_ns, CNT_W4));
    checkOutput({tag, "_n_err4"}, n_err4, sat(m_ne, CNT_W4));
    checkOutput({tag, "_n_oor4"}, n_oor4, sat(m_noor, CNT_W4));
    checkOutput({tag, "_sum_ed_q4"}, sum_ed_q4, sat(m_sum, SUM_W));
    checkOutput({tag, "_max_ed_q4"}, max_ed_q4, m_max);
  endtask

  // Transfers one sample and returns the cycle (after the transfer edge) in which upd rose.
  task automatic applyStimulus(input logic [15:0] vx, input logic [7:0] vy,
                               input logic [7:0] vq, input logic [7:0] vr,
                               output int lat);
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 30) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) checkOutput("ready_timeout", 0, 1);
    in_valid = 1'b1; x = vx; y = vy; q_app = vq; r_app = vr;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = 16'($urandom); y = 8'($urandom); q_app = 8'($urandom); r_app = 8'($urandom);
    modelAccept(vx, vy, vq, vr);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      if (upd) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic pulseClear();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    modelClear();
  endtask

  initial begin
    int lat;
    int lowc, nx, bad;
    logic rdy;
    logic [15:0] bx[3];
    logic [7:0]  by[3], bq[3], br[3];
    int xe[3];
    logic [15:0] rx;
    logic [7:0]  ry, rq, rr, hi;
    int qe, re;

    vecs[0] = '{16'h1234, 8'h56, 8'h36, 8'h10, 10, 1, 0, 0, 0, 0};
    vecs[1] = '{16'h1234, 8'h56, 8'h34, 8'h10, 10, 2, 1, 0, 2, 2};
    vecs[2] = '{16'h1234, 8'h00, 8'h00, 8'h00,  2, 2, 1, 1, 2, 2};
    vecs[3] = '{16'h9000, 8'h80, 8'h00, 8'h00,  2, 2, 1, 2, 2, 2};
    vecs[4] = '{16'h7FFF, 8'h80, 8'h00, 8'h7F, 10, 3, 2, 2, 257, 255};
    vecs[5] = '{16'h00FF, 8'h01, 8'hFF, 8'h01, 10, 4, 3, 2, 257, 255};
    vecs[6] = '{16'h0100, 8'h01, 8'h00, 8'h00,  2, 4, 3, 3, 257, 255};

    modelClear();
    rst_n = 1'b0;
    #12;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_in_ready4", in_ready4, 1);
    checkOutput("reset_upd", upd, 0);
    checkStats("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].vx, vecs[i].vy, vecs[i].vq, vecs[i].vr, lat);
      checkOutput($sformatf("vec%0d_latency", i), longint'(lat), longint'(vecs[i].lat));
      checkOutput($sformatf("vec%0d_n_samples", i), n_samples, vecs[i].ns);
      checkOutput($sformatf("vec%0d_n_err", i), n_err, vecs[i].ne);
      checkOutput($sformatf("vec%0d_n_oor", i), n_oor, vecs[i].noor);
      checkOutput($sformatf("vec%0d_sum_ed_q", i), sum_ed_q, vecs[i].sum);
      checkOutput($sformatf("vec%0d_max_ed_q", i), max_ed_q, vecs[i].mx);
      checkOutput($sformatf("vec%0d_in_ready", i), in_ready, 1);
      checkOutput($sformatf("vec%0d_upd4", i), upd4, 1);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_upd_pulse", i), upd, 0);
    end
    checkStats("table");

    // Back-to-back: in_valid held high across three in-range samples.
    bx[0] = 16'h1234; by[0] = 8'h56; bq[0] = 8'h36; br[0] = 8'h10;
    bx[1] = 16'h0001; by[1] = 8'h02; bq[1] = 8'h00; br[1] = 8'h01;
    bx[2] = 16'h7F00; by[2] = 8'hFF; bq[2] = 8'h00; br[2] = 8'h00;
    for (int i = 0; i < 3; i++) xe[i] = -1;
    nx = 0; lowc = 0;
    in_valid = 1'b1; x = bx[0]; y = by[0]; q_app = bq[0]; r_app = br[0];
    for (int e = 0; e < 30; e++) begin
      rdy = in_ready;
      if (rdy && nx < 3) xe[nx] = e;
      else if (!rdy && e >= 1 && e <= 9) lowc++;
      @(posedge clk); #1;
      if (rdy && nx < 3) begin
        modelAccept(x, y, q_app, r_app);
        nx++;
        if (nx < 3) begin
          x = bx[nx]; y = by[nx]; q_app = bq[nx]; r_app = br[nx];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    checkOutput("b2b_xfer0_edge", longint'(xe[0]), 0);
    checkOutput("b2b_xfer1_edge", longint'(xe[1]), 10);
    checkOutput("b2b_xfer2_edge", longint'(xe[2]), 20);
    checkOutput("b2b_not_ready_cycles", longint'(lowc), 9);
    checkOutput("b2b_last_upd", upd, 1);
    checkStats("b2b");
    @(posedge clk); #1;

    // clr in DIV cycle 4 with in_valid high: abort, zero, no upd, nothing accepted.
    in_valid = 1'b1; x = 16'h1234; y = 8'h56; q_app = 8'h00; r_app = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    checkOutput("clr_div_busy", in_ready, 0);
    clr = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    modelClear();
    checkOutput("clr_div_idle", in_ready, 1);
    checkOutput("clr_div_upd", upd, 0);
    checkStats("clr_div");
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (upd || !in_ready) bad++;
    end
    checkOutput("clr_div_dropped", longint'(bad), 0);

    // clr in the ACC cycle of an out-of-range sample suppresses its update.
    in_valid = 1'b1; x = 16'h0500; y = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checkOutput("clr_acc_upd", upd, 0);
    checkStats("clr_acc");

    // clr in IDLE with in_valid high must not start a sample.
    clr = 1'b1; in_valid = 1'b1; x = 16'h1234; y = 8'h56;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    checkOutput("clr_idle_not_accepted", in_ready, 1);
    bad = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (upd) bad++;
    end
    checkOutput("clr_idle_no_upd", longint'(bad), 0);

    // Randomized samples, mostly in range, with occasional perturbed results.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        rx = 16'($urandom); ry = 8'($urandom_range(0, 255));
      end else begin
        ry = 8'($urandom_range(1, 255));
        hi = 8'($urandom_range(0, int'(ry) - 1));
        rx = {hi, 8'($urandom)};
      end
      if (ry != 0) begin
        qe = int'(rx) / int'(ry);
        re = int'(rx) % int'(ry);
      end else begin
        qe = 0; re = 0;
      end
      rq = ($urandom_range(0, 2) == 0) ? 8'(qe + int'($urandom_range(1, 255))) : 8'(qe);
      rr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(re);
      applyStimulus(rx, ry, rq, rr, lat);
      checkOutput($sformatf("rand%0d_latency", i), longint'(lat), isOor(rx, ry) ? 2 : 10);
      checkStats($sformatf("rand%0d", i));
      @(posedge clk); #1;
    end

    // Saturation: 20 matching samples after a clear.
    pulseClear();
    checkStats("sat_clr");
    for (int i = 0; i < 20; i++) begin
      ry = 8'($urandom_range(1, 255));
      hi = 8'($urandom_range(0, int'(ry) - 1));
      rx = {hi, 8'($urandom)};
      rq = 8'(int'(rx) / int'(ry));
      rr = 8'(int'(rx) % int'(ry));
      applyStimulus(rx, ry, rq, rr, lat);
      checkStats($sformatf("sat%0d", i));
      @(posedge clk); #1;
    end
    checkOutput("sat_n_samples_wide", n_samples, 20);
    checkOutput("sat_n_samples_narrow", n_samples4, 15);
    checkOutput("sat_n_err_narrow", n_err4, 0);

    // Asynchronous reset in the middle of DIV.
    in_valid = 1'b1; x = 16'h1234; y = 8'h56; q_app = 8'h00; r_app = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    modelClear();
    checkOutput("rst_mid_in_ready", in_ready, 1);
    checkOutput("rst_mid_upd", upd, 0);
    checkStats("rst_mid");
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(16'h1234, 8'h56, 8'h30, 8'h10, lat);
    checkOutput("post_rst_latency", longint'(lat), 10);
    checkStats("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
